// File: rtl/proc_pkg.sv
// Shared opcodes, state encoding and Done-step constants
// for the bus processor program sequencer.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_I,
    S_LOAD_I,
    S_FETCH_D,
    S_LOAD_D,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } seq_state_t;

  localparam logic [1:0] STEP_MV  = 2'd1;
  localparam logic [1:0] STEP_ALU = 2'd3;

  function automatic logic [1:0] done_step(
    input logic [2:0] op
  );
    return (op == OP_ADD || op == OP_SUB)
      ? STEP_ALU : STEP_MV;
  endfunction

  function automatic logic is_nop(
    input logic [2:0] op
  );
    return op[2] && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/proc_sequencer_upcount.sv
// 2-bit up counter with synchronous clear; tracks the
// processor time step while the processor is released.
module upcount (
  input  logic       Clear,
  input  logic       Clock,
  output logic [1:0] Q
);

  always_ff @(posedge Clock) begin
    if (Clear) Q <= '0;
    else       Q <= Q + 2'd1;
  end

endmodule

// File: rtl/proc_sequencer.sv
// Program sequencer: streams ROM words onto the processor
// DIN and gates it one instruction at a time via Resetn.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  output logic [AW-1:0] ADDR,
  input  logic [15:0]   ROM_Q,
  output logic [15:0]   DIN,
  output logic          ProcResetn,
  input  logic          Done,
  output logic          Busy,
  output logic          Halted,
  output logic          Fault,
  output logic [AW-1:0] PC,
  output logic [15:0]   InstrCount
);

  seq_state_t state, state_nxt;

  logic [AW-1:0] pc;
  logic [15:0]   ir_s;
  logic [15:0]   imm_s;
  logic [15:0]   cnt;
  logic [1:0]    ec;
  logic          ec_clr;
  logic [2:0]    rom_op;
  logic [2:0]    ir_op;
  logic [1:0]    step;
  logic          idle_like;
  logic          start_ok;
  logic          at_step;
  logic          cnt_inc;

  assign rom_op = ROM_Q[8:6];
  assign ir_op  = ir_s[8:6];
  assign step   = done_step(ir_op);
  assign at_step = (ec == step);

  assign idle_like = (state == S_IDLE)
                  || (state == S_HALTED)
                  || (state == S_FAULT);
  assign start_ok  = Start && idle_like;

  assign cnt_inc =
      ((state == S_LOAD_I) && is_nop(rom_op))
   || ((state == S_EXEC) && at_step && Done);

  // Holding ec at 0 outside EXEC keeps it in lockstep
  // with the processor's own step counter.
  assign ec_clr = (state != S_EXEC) || Reset;

  upcount u_ec (
    .Clear (ec_clr),
    .Clock (Clock),
    .Q     (ec)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE,
      S_HALTED,
      S_FAULT: begin
        if (Start) state_nxt = S_FETCH_I;
      end
      S_FETCH_I: state_nxt = S_LOAD_I;
      S_LOAD_I: begin
        unique case (1'b1)
          (rom_op == OP_HALT): state_nxt = S_HALTED;
          is_nop(rom_op):      state_nxt = S_FETCH_I;
          (rom_op == OP_MVI):  state_nxt = S_FETCH_D;
          default:             state_nxt = S_EXEC;
        endcase
      end
      S_FETCH_D: state_nxt = S_LOAD_D;
      S_LOAD_D:  state_nxt = S_EXEC;
      S_EXEC: begin
        if (at_step)
          state_nxt = Done ? S_FETCH_I : S_FAULT;
        else if (Done)
          state_nxt = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir_s  <= '0;
      imm_s <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        pc  <= StartAddr;
        cnt <= '0;
      end else if (cnt_inc && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
      if (state == S_LOAD_I) begin
        ir_s <= ROM_Q;
        pc   <= pc + AW'(1);
      end
      if (state == S_LOAD_D) begin
        imm_s <= ROM_Q;
        pc    <= pc + AW'(1);
      end
    end
  end

  assign ADDR       = pc;
  assign PC         = pc;
  assign InstrCount = cnt;

  assign DIN = ((state == S_EXEC) && (ec == 2'd1)
             && (ir_op == OP_MVI)) ? imm_s : ir_s;

  assign ProcResetn = (state == S_EXEC);
  assign Busy   = (state == S_FETCH_I)
               || (state == S_LOAD_I)
               || (state == S_FETCH_D)
               || (state == S_LOAD_D)
               || (state == S_EXEC);
  assign Halted = (state == S_HALTED);
  assign Fault  = (state == S_FAULT);

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Program sequencer for the 16-bit bus processor. It fetches instruction words and mvi immediates from a synchronous program ROM and presents each word on the processor's DIN at the exact time step the processor samples it. It gates the processor through its active-low reset so it never free-runs between instructions, checks that Done arrives on the expected cycle, and stops on a HALT opcode. It sits between the ROM and `proc`, replacing the manual DIN switches and Run button.

## Interface
- AW, 8, ROM address width; PC wraps modulo 2^AW.
- Clock  in  1  sole clock; all flops on posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  begins execution from StartAddr; honoured only in IDLE, HALTED or FAULT.
- StartAddr  in  AW  first program address.
- ADDR  out  AW  ROM address; ROM_Q is valid one cycle after ADDR.
- ROM_Q  in  16  ROM read data.
- DIN  out  16  processor DIN.
- ProcResetn  out  1  processor Resetn; 1 only in EXEC.
- Done  in  1  processor Done.
- Busy  out  1  high in FETCH_I, LOAD_I, FETCH_D, LOAD_D, EXEC.
- Halted  out  1  high in HALTED.
- Fault  out  1  high in FAULT.
- PC  out  AW  address of the next word to fetch.
- InstrCount  out  16  instructions retired since Start; saturates at 16'hFFFF.

## Operation
- Decode: opcode = word[8:6], X = word[5:3], Y = word[2:0].
  - 000 mv, 001 mvi, 010 add, 011 sub: executed.
  - 111 HALT.
  - 100–110 NOP: skipped; the processor is never released for these.
- States:
  - IDLE: on Start, PC <= StartAddr, go to FETCH_I.
  - FETCH_I: ADDR = PC. Go to LOAD_I.
  - LOAD_I: IR_s <= ROM_Q, PC <= PC+1. Next state by opcode: HALT goes to HALTED; NOP goes to FETCH_I and increments InstrCount; mvi goes to FETCH_D; otherwise EXEC.
  - FETCH_D: ADDR = PC. Go to LOAD_D.
  - LOAD_D: IMM_s <= ROM_Q, PC <= PC+1. Go to EXEC.
  - EXEC: ProcResetn = 1. Exec step ec starts at 0 and increments each cycle.
    - DIN = IMM_s when ec==1 and opcode is mvi; otherwise DIN = IR_s.
    - Expected Done step E = 1 for mv/mvi, 3 for add/sub.
    - Done sampled 1 at ec==E: InstrCount++, go to FETCH_I.
    - Done 1 at ec<E, or 0 at ec==E: go to FAULT.
  - HALTED, FAULT: ProcResetn = 0. Start restarts as from IDLE.
- Outputs other than the registered PC, InstrCount, IR_s and IMM_s are decoded from the state register (Moore). In every state except EXEC, DIN = IR_s and ProcResetn = 0.
- Start during a busy state is ignored.
- InstrCount clears on an accepted Start.
- PC wraps from 2^AW−1 to 0 with no flag.

## Timing
- Reset: state IDLE; PC, ADDR, IR_s, IMM_s, InstrCount, DIN = 0; ProcResetn, Busy, Halted, Fault = 0.
- Reset asserted mid-EXEC: ProcResetn falls after that edge, which aborts the processor step counter; any partial instruction is discarded.
- Cycles per instruction, measured from FETCH_I entry:
  - mv: 4.
  - mvi: 6.
  - add/sub: 6.
  - NOP: 2.
  - HALT: 2, then Halted is high.
- The processor step counter is held at 0 by ProcResetn = 0, so EXEC ec tracks the processor time step exactly. Its IR loads IR_s at ec==0.
- Done is combinational from the processor and sampled at the posedge ending ec==E. That same edge clears the processor counter.

## Structure
- Shared package `proc_pkg`:
  - opcode localparams OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_HALT=3'b111;
  - the state encoding;
  - the expected-Done step constants.
- Sub-module: the existing 2-bit `upcount` serves as the ec counter. Its clear is tied to (state != EXEC) || Reset.

## Test plan
- ROM[0..4] = mvi R0 (0x0040), 0x0005, mv R1,R0 (0x0008), add R0,R1 (0x0081), HALT (0x01C0); Start with StartAddr=0.
  - Required: bus carries 5 at mvi T1 and 10 at the add result step.
  - Required: Halted after 18 cycles; InstrCount = 3; PC = 5.
- sub R2,R0 with R2=3, R0=5: bus carries 0xFFFE at the Gout step; Done is seen at ec==3.
- Opcode 0x0100 (NOP) between two mv instructions: ProcResetn stays 0 for its 2 cycles; InstrCount increments by 3.
- Force Done=0 during a mv: Fault is set at the end of ec==1 and ProcResetn = 0. A subsequent Start clears Fault and resumes execution.
- StartAddr = 0xFF, AW=8, mvi at 0xFF with its immediate at 0x00: the immediate is fetched from 0x00 and PC = 0x01 afterward.
- Reset asserted at ec==2 of an add: all outputs return to reset values next cycle, and G is not written to Rx.
